spatial_encoder_nmod: RTL

Parametrised spatial encoder for the HD sensor-fusion pipeline. It generalises the fixed three-modality SRAM-fed encoder to N modalities, each with its own channel count and SRAM address stream. Each channel's item-memory vector is bound to a sign-selected projection vector and accumulated into a per-modality bit-count majority. The N per-modality hypervectors are then combined by an N-way majority. The block sits between the input feature buffer and the temporal encoder, and streams vectors from per-modality SRAM banks.

---
 rtl/spatial_encoder_nmod_pkg.sv | 40 ++++
 rtl/spatial_accumulator_n.sv | 74 +++++++
 rtl/spatial_encoder_nmod.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spatial_encoder_nmod_pkg.sv
// Shared definitions for the N-modality spatial encoder: default widths, FSM
// state encoding and helpers that unpack the MOD_CHANNELS parameter.
package spatial_encoder_nmod_pkg;

    localparam int DEF_HV_DIMENSION  = 2000;
    localparam int DEF_CHANNEL_WIDTH = 8;

    // MOD_CHANNELS packs one 8-bit channel count per modality, modality 0 in the MSB slot
    localparam int MOD_FIELD_W    = 8;
    localparam int MAX_MODALITIES = 16;

    typedef logic [MAX_MODALITIES*MOD_FIELD_W-1:0] mod_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_FINALIZE = 2'd2,
        ST_OUTPUT   = 2'd3
    } state_t;

    function automatic int mod_field(input mod_vec_t v, input int n, input int m);
        return int'(v[(n-1-m)*MOD_FIELD_W +: MOD_FIELD_W]);
    endfunction

    // Sum of channel counts of modalities below m; with m == n this is the total.
    function automatic int mod_offset(input mod_vec_t v, input int n, input int m);
        int acc;
        acc = 0;
        for (int i = 0; i < m; i++) acc += mod_field(v, n, i);
        return acc;
    endfunction

    function automatic int mod_max(input mod_vec_t v, input int n);
        int r;
        r = 0;
        for (int i = 0; i < n; i++) if (mod_field(v, n, i) > r) r = mod_field(v, n, i);
        return r;
    endfunction

endpackage

// File: rtl/spatial_accumulator_n.sv
// One modality of the spatial encoder: binds IM rows to sign-selected projection
// rows, keeps per-bit counts and thresholds them. SPATIAL_TIEBREAK_EN adds tie-break.
module spatial_accumulator_n
    import spatial_encoder_nmod_pkg::*;
#(
    parameter int HV_DIMENSION  = DEF_HV_DIMENSION,
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int MAX_CHANNELS  = 128,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                     Clk_CI,
    input  logic                     Reset_RI,
    input  logic                     Clear_SI,
    input  logic                     Accum_SI,
    input  logic                     First_SI,
    input  logic                     Second_SI,
    input  logic [CHANNEL_WIDTH-1:0] Feature_DI,
    input  logic [HV_DIMENSION-1:0]  IMData_DI,
    input  logic [HV_DIMENSION-1:0]  ProjNeg_DI,
    input  logic [HV_DIMENSION-1:0]  ProjPos_DI,
    output logic [HV_DIMENSION-1:0]  Result_DO
);

    localparam int CNT_W = $clog2(MAX_CHANNELS + 1);
    localparam logic [CNT_W:0] THRESH = (CNT_W+1)'(NUM_CHANNELS);

    logic [CNT_W-1:0]        count_q [HV_DIMENSION];
    logic [HV_DIMENSION-1:0] tie_q;
    logic [HV_DIMENSION-1:0] bound;
    logic                    positive;
    logic [CNT_W:0]          dbl;

    // Zero counts as non-positive and selects the negative projection.
    assign positive = ~Feature_DI[CHANNEL_WIDTH-1] & (|Feature_DI);
    assign bound    = IMData_DI ^ (positive ? ProjPos_DI : ProjNeg_DI);

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI || Clear_SI) begin
            for (int b = 0; b < HV_DIMENSION; b++) count_q[b] <= '0;
        end else if (Accum_SI) begin
            for (int b = 0; b < HV_DIMENSION; b++)
                if (bound[b] && (count_q[b] != '1)) count_q[b] <= count_q[b] + 1'b1;
        end
    end

`ifdef SPATIAL_TIEBREAK_EN
    // Tie-break vector is bound(channel 0) XOR bound(channel 1).
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI || Clear_SI) begin
            tie_q <= '0;
        end else if (Accum_SI && First_SI) begin
            tie_q <= bound;
        end else if (Accum_SI && Second_SI) begin
            tie_q <= tie_q ^ bound;
        end
    end
`else
    logic unused_idx;
    assign unused_idx = First_SI ^ Second_SI;
    assign tie_q      = '0;
`endif

    always_comb begin
        Result_DO = '0;
        dbl       = '0;
        for (int b = 0; b < HV_DIMENSION; b++) begin
            dbl = {count_q[b], 1'b0};
            if (dbl > THRESH)       Result_DO[b] = 1'b1;
            else if (dbl == THRESH) Result_DO[b] = tie_q[b];
            else                    Result_DO[b] = 1'b0;
        end
    end

endmodule

// File: rtl/spatial_encoder_nmod.sv
// N-modality spatial encoder: streams IM/projection rows per modality from SRAM,
// accumulates per-modality majorities, fuses them by N-way majority. Option: SPATIAL_TIEBREAK_EN.
module spatial_encoder_nmod
    import spatial_encoder_nmod_pkg::*;
#(
    parameter int HV_DIMENSION   = DEF_HV_DIMENSION,
    parameter int CHANNEL_WIDTH  = DEF_CHANNEL_WIDTH,
    parameter int NUM_MODALITIES = 3,
    parameter int MAX_CHANNELS   = 128,
    parameter logic [MOD_FIELD_W*NUM_MODALITIES-1:0] MOD_CHANNELS = {8'd32, 8'd77, 8'd105},
    parameter int ADDR_WIDTH     = $clog2(MAX_CHANNELS),
    localparam mod_vec_t MOD_EXT = mod_vec_t'(MOD_CHANNELS),
    localparam int TOTAL_CH      = mod_offset(MOD_EXT, NUM_MODALITIES, NUM_MODALITIES),
    localparam int MAX_C         = mod_max(MOD_EXT, NUM_MODALITIES)
) (
    input  logic                                   Clk_CI,
    input  logic                                   Reset_RI,
    input  logic                                   ValidIn_SI,
    output logic                                   ReadyOut_SO,
    input  logic [TOTAL_CH*CHANNEL_WIDTH-1:0]      ChannelsInput_DI,
    output logic                                   ValidOut_SO,
    input  logic                                   ReadyIn_SI,
    output logic [HV_DIMENSION-1:0]                HypervectorOut_DO,
    output logic [NUM_MODALITIES-1:0]              SramReq_SO,
    output logic [NUM_MODALITIES*ADDR_WIDTH-1:0]   SramAddr_DO,
    input  logic [NUM_MODALITIES-1:0]              SramValid_SI,
    input  logic [NUM_MODALITIES*HV_DIMENSION-1:0] IMData_DI,
    input  logic [NUM_MODALITIES*HV_DIMENSION-1:0] ProjNeg_DI,
    input  logic [NUM_MODALITIES*HV_DIMENSION-1:0] ProjPos_DI,
    output logic [1:0]                             DbgState_DO
);

    if (NUM_MODALITIES % 2 == 0) begin : g_bad_num_modalities
        $error("NUM_MODALITIES must be odd");
    end
    if (NUM_MODALITIES > MAX_MODALITIES) begin : g_too_many_modalities
        $error("NUM_MODALITIES exceeds MAX_MODALITIES");
    end

    state_t                              state_q;
    logic [ADDR_WIDTH-1:0]               cnt_q;
    logic [NUM_MODALITIES-1:0]           req_q;
    logic [NUM_MODALITIES-1:0]           req_next;
    logic                                valid_q;
    logic [HV_DIMENSION-1:0]             hv_q;
    logic [TOTAL_CH*CHANNEL_WIDTH-1:0]   feat_q;
    logic [HV_DIMENSION-1:0]             mod_res [NUM_MODALITIES];
    logic [HV_DIMENSION-1:0]             fused;
    logic                                start;
    logic                                advance;
    logic                                last;
    int                                  ones;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid
    // and ready are both 1; valid never drops and data never changes until then.
    assign ReadyOut_SO       = (state_q == ST_IDLE) & ~Reset_RI;
    assign ValidOut_SO       = valid_q;
    assign HypervectorOut_DO = hv_q;
    assign SramReq_SO        = req_q;
    assign SramAddr_DO       = {NUM_MODALITIES{cnt_q}};
    assign DbgState_DO       = state_q;

    assign start   = (state_q == ST_IDLE) && ValidIn_SI;
    // Finished modalities have req_q low, so they never hold back the others.
    assign advance = (state_q == ST_ACCUM) && (&(SramValid_SI | ~req_q));
    assign last    = (cnt_q == ADDR_WIDTH'(MAX_C - 1));

    for (genvar m = 0; m < NUM_MODALITIES; m++) begin : g_mod
        localparam int C_M   = mod_field(MOD_EXT, NUM_MODALITIES, m);
        localparam int OFF_M = mod_offset(MOD_EXT, NUM_MODALITIES, m);

        if (C_M < 1 || C_M > MAX_CHANNELS) begin : g_bad_channels
            $error("MOD_CHANNELS entry out of range");
        end

        logic [CHANNEL_WIDTH-1:0] feat;

        always_comb begin
            feat = '0;
            for (int c = 0; c < C_M; c++)
                if (cnt_q == ADDR_WIDTH'(c)) feat = feat_q[(OFF_M+c)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end

        assign req_next[m] = (int'(cnt_q) + 1) < C_M;

        spatial_accumulator_n #(
            .HV_DIMENSION (HV_DIMENSION),
            .CHANNEL_WIDTH(CHANNEL_WIDTH),
            .MAX_CHANNELS (MAX_CHANNELS),
            .NUM_CHANNELS (C_M)
        ) u_acc (
            .Clk_CI    (Clk_CI),
            .Reset_RI  (Reset_RI),
            .Clear_SI  (start),
            .Accum_SI  (advance & req_q[m]),
            .First_SI  (cnt_q == '0),
            .Second_SI (cnt_q == ADDR_WIDTH'(1)),
            .Feature_DI(feat),
            .IMData_DI (IMData_DI[m*HV_DIMENSION +: HV_DIMENSION]),
            .ProjNeg_DI(ProjNeg_DI[m*HV_DIMENSION +: HV_DIMENSION]),
            .ProjPos_DI(ProjPos_DI[m*HV_DIMENSION +: HV_DIMENSION]),
            .Result_DO (mod_res[m])
        );
    end

    always_comb begin
        fused = '0;
        ones  = 0;
        for (int b = 0; b < HV_DIMENSION; b++) begin
            ones = 0;
            for (int m = 0; m < NUM_MODALITIES; m++) ones += int'(mod_res[m][b]);
            fused[b] = (ones > NUM_MODALITIES / 2);
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            valid_q <= 1'b0;
            hv_q    <= '0;
            feat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ValidIn_SI) begin
                        feat_q  <= ChannelsInput_DI;
                        cnt_q   <= '0;
                        req_q   <= '1;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (advance) begin
                        req_q <= req_next;
                        if (last) begin
                            cnt_q   <= '0;
                            state_q <= ST_FINALIZE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_FINALIZE: begin
                    hv_q    <= fused;
                    valid_q <= 1'b1;
                    state_q <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (ReadyIn_SI) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
